// File: rtl/adder_pipe_pkg.sv
// Shared types and mode encodings for the pipelined multi-lane approximate adder.
package adder_pipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_EXACT = 2'd0;
  localparam mode_t MODE_LOA   = 2'd1;
  localparam mode_t MODE_TRUNC = 2'd2;
  localparam mode_t MODE_RSVD  = 2'd3;

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry-split segment of the adder for all lanes: adds segment IDX, registers its carry,
// and forwards operands, mode, valid and the partially assembled sum to the next stage.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned STAGES      = 4,
  parameter int unsigned APPROX_BITS = 4,
  parameter bit          SIGNED      = 1'b0,
  parameter int unsigned IDX         = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  mode_t                      i_mode,
  input  logic [LANES*WIDTH-1:0]     i_a,
  input  logic [LANES*WIDTH-1:0]     i_b,
  input  logic [LANES-1:0]           i_carry,
  input  logic [LANES*(WIDTH+1)-1:0] i_sum,
  output logic                       o_valid,
  output mode_t                      o_mode,
  output logic [LANES*WIDTH-1:0]     o_a,
  output logic [LANES*WIDTH-1:0]     o_b,
  output logic [LANES-1:0]           o_carry,
  output logic [LANES*(WIDTH+1)-1:0] o_sum
);

  localparam int unsigned SegW = WIDTH / STAGES;
  localparam int unsigned Lo   = IDX * SegW;
  localparam logic [SegW-1:0] LowMask = ~({SegW{1'b1}} << APPROX_BITS);
  // Top bit of the approximate part: its AND generates the LOA carry.
  localparam logic [SegW-1:0] LoaMask = LowMask & ~(LowMask >> 1);

  logic [SegW-1:0]              w_a_seg;
  logic [SegW-1:0]              w_b_seg;
  logic [SegW:0]                w_exact;
  logic [SegW:0]                w_hi;
  logic [SegW:0]                w_res;
  logic                         w_cin_apx;
  logic                         w_apx;
  logic [LANES*(WIDTH+1)-1:0]   w_sum;
  logic [LANES-1:0]             w_carry;

  always_comb begin
    w_sum     = i_sum;
    w_carry   = '0;
    w_a_seg   = '0;
    w_b_seg   = '0;
    w_exact   = '0;
    w_hi      = '0;
    w_res     = '0;
    w_cin_apx = 1'b0;
    w_apx     = (IDX == 0) && (i_mode == MODE_LOA || i_mode == MODE_TRUNC);
    for (int l = 0; l < LANES; l++) begin
      w_a_seg   = i_a[l*WIDTH + Lo +: SegW];
      w_b_seg   = i_b[l*WIDTH + Lo +: SegW];
      w_exact   = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SegW{1'b0}}, i_carry[l]};
      w_cin_apx = (i_mode == MODE_LOA) && |(w_a_seg & w_b_seg & LoaMask);
      // Exact add of the bits above the approximate part; realigned by the shift below.
      w_hi      = {1'b0, w_a_seg >> APPROX_BITS} + {1'b0, w_b_seg >> APPROX_BITS}
                + {{SegW{1'b0}}, w_cin_apx};
      w_res     = w_apx ? ((w_hi << APPROX_BITS)
                           | {1'b0, (w_a_seg | w_b_seg) & LowMask & {SegW{i_mode == MODE_LOA}}})
                        : w_exact;
      w_sum[l*(WIDTH+1) + Lo +: SegW] = w_res[SegW-1:0];
      w_carry[l] = w_res[SegW];
      if (IDX == STAGES - 1) begin
        w_sum[l*(WIDTH+1) + WIDTH] = SIGNED ? (i_a[l*WIDTH + WIDTH-1] ^ i_b[l*WIDTH + WIDTH-1]
                                               ^ w_res[SegW])
                                            : w_res[SegW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_mode  <= MODE_EXACT;
      o_a     <= '0;
      o_b     <= '0;
      o_carry <= '0;
      o_sum   <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_mode  <= i_mode;
      o_a     <= i_a;
      o_b     <= i_b;
      o_carry <= w_carry;
      o_sum   <= w_sum;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Multi-lane pipelined adder with exact, lower-part-OR and truncated modes; one segment per
// stage, valid/ready flow control with a global stall.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned STAGES      = 4,
  parameter int unsigned APPROX_BITS = 4,
  parameter bit          SIGNED      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     A,
  input  logic [LANES*WIDTH-1:0]     B,
  input  logic [LANES-1:0]           Carry,
  input  mode_t                      mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*(WIDTH+1)-1:0] OUT
);

  logic                       w_advance;
  logic                       w_valid [STAGES+1];
  mode_t                      w_mode  [STAGES+1];
  logic [LANES*WIDTH-1:0]     w_a     [STAGES+1];
  logic [LANES*WIDTH-1:0]     w_b     [STAGES+1];
  logic [LANES-1:0]           w_carry [STAGES+1];
  logic [LANES*(WIDTH+1)-1:0] w_sum   [STAGES+1];

  // All stages move together; an empty output slot or a taken result frees the pipe.
  assign w_advance  = ~out_valid | out_ready;
  assign in_ready   = w_advance;

  assign w_valid[0] = in_valid;
  assign w_mode[0]  = mode;
  assign w_a[0]     = A;
  assign w_b[0]     = B;
  assign w_carry[0] = Carry;
  assign w_sum[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH       (WIDTH),
      .LANES       (LANES),
      .STAGES      (STAGES),
      .APPROX_BITS (APPROX_BITS),
      .SIGNED      (SIGNED),
      .IDX         (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_advance),
      .i_valid (w_valid[k]),
      .i_mode  (w_mode[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .i_carry (w_carry[k]),
      .i_sum   (w_sum[k]),
      .o_valid (w_valid[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1]),
      .o_carry (w_carry[k+1]),
      .o_sum   (w_sum[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign OUT       = w_sum[STAGES];

  logic w_unused;
  assign w_unused = ^{w_mode[STAGES], w_a[STAGES], w_b[STAGES], w_carry[STAGES]};

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width per lane.
REQ-002 Parameter LANES, default 4: independent adder lanes processed in lock-step.
REQ-003 Parameter STAGES, default 4: carry-split pipeline segments; WIDTH % STAGES == 0 is required.
REQ-004 Parameter APPROX_BITS, default 4: approximate low-part width; 0 <= APPROX_BITS <= WIDTH/STAGES is required.
REQ-005 Parameter SIGNED, default 0: 1 selects two's-complement operands with a sign-extended result.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  beat present on A, B, Carry, mode.
REQ-009 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-010 A  input  LANES*WIDTH  lane operands, lane 0 in the LSBs.
REQ-011 B  input  LANES*WIDTH  lane operands, lane 0 in the LSBs.
REQ-012 Carry  input  LANES  per-lane carry-in.
REQ-013 mode  input  2  adder type for this beat.
REQ-014 out_valid  output  1  result beat present.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 OUT  output  LANES*(WIDTH+1)  per-lane full-width sum.

Function
REQ-017 Modes: 0 exact; 1 LOA; 2 truncated; 3 reserved, behaves as exact.
REQ-018 mode and Carry shall be captured with each beat and travel with it; a mode change never affects beats already in flight.
REQ-019 Exact mode: OUT lane = A + B + Carry, computed in WIDTH+1 bits; operands are sign-extended when SIGNED=1 and zero-extended otherwise.
REQ-020 LOA mode: result bits [APPROX_BITS-1:0] = A|B; carry into bit APPROX_BITS = A[APPROX_BITS-1] & B[APPROX_BITS-1]; Carry is ignored; the upper part is added exactly.
REQ-021 Truncated mode: result bits [APPROX_BITS-1:0] = 0; no carry into bit APPROX_BITS; Carry is ignored; the upper part is added exactly.
REQ-022 With APPROX_BITS=0, LOA and truncated modes shall equal exact mode except that Carry is ignored.
REQ-023 Pipeline: segment k (bits k*W/S .. (k+1)*W/S-1) is added in stage k using the registered carry from stage k-1.
REQ-024 Low result segments shall be delayed so that all segments of a beat emerge aligned.
REQ-025 Stage STAGES-1 also forms the sign/carry bit WIDTH.
REQ-026 Latency is exactly STAGES cycles from acceptance to out_valid when no stall occurs; throughput is 1 beat/cycle.
REQ-027 Flow control: the pipeline advances when advance = ~out_valid | out_ready; in_ready = advance; all stages stall together.
REQ-028 Bubbles are permitted: each stage carries a valid bit, and invalid stages shall never assert out_valid.
REQ-029 Under stall, OUT and out_valid shall hold stable and no beat shall be dropped or duplicated; beats leave in acceptance order.
REQ-030 A beat may be accepted and another emitted in the same cycle.

Reset
REQ-031 rst_n low shall immediately clear all stage valid bits, force out_valid=0 and OUT=0, and zero all data and carry registers.
REQ-032 Beats in flight when reset asserts are discarded.
REQ-033 in_ready shall be 1 from the first edge after reset release.

Structure
REQ-034 Package adder_pipe_pkg shall hold the mode constants MODE_EXACT=0, MODE_LOA=1, MODE_TRUNC=2, MODE_RSVD=3, and the 2-bit mode type.
REQ-035 Sub-module adder_pipe_stage shall implement one segment slice for all lanes (segment add, carry register, valid/mode/data forwarding).
REQ-036 adder_pipe shall instantiate adder_pipe_stage STAGES times via generate.
REQ-037 The approximate low part shall be implemented in stage 0 only.

Verification (WIDTH=16, LANES=2, STAGES=4, APPROX_BITS=4)
REQ-038 Exact mode, A=0xFFFF, B=0x0001, Carry=0 -> OUT=0x10000 with out_valid exactly 4 cycles after acceptance (full carry ripple).
REQ-039 LOA mode, A=0x000F, B=0x0009, Carry=1 -> OUT=0x0001F; exact mode on the same operands -> 0x00019.
REQ-040 Truncated mode, A=0x1234, B=0x0F0F -> OUT=0x02130; exact mode -> 0x02143.
REQ-041 SIGNED=1, exact mode, A=0x8000, B=0x8000 -> OUT=0x10000 (-65536); A=0xFFFF, B=0x0001 -> 0x00000.
REQ-042 Stream 8 beats with alternating modes and out_ready low for cycles 3-5 -> all 8 results correct, in order, OUT stable while stalled, in_ready low during the stall.
REQ-043 Assert rst_n low with 3 beats in flight -> out_valid=0 at once; no stale beat appears after release; the next accepted beat emerges after 4 cycles.
